// File: rtl/ram_mmu_pkg.sv
// Shared constants and the flush-sequencer state type for the MMU/TLB storage RAM.
package ram_mmu_pkg;

  localparam int WR_NO_CHANGE   = 0;
  localparam int WR_WRITE_FIRST = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/ram_mmu_flush_tech_if.sv
// Request/response bundle between the MMU/TLB controller (master) and the storage RAM (slave).
interface ram_mmu_flush_tech_if #(
  parameter int abits = 6,
  parameter int dbits = 104
) ();

  logic             i_req_valid;
  logic             o_req_ready;
  logic [abits-1:0] i_addr;
  logic             i_wena;
  logic [dbits-1:0] i_wmask;
  logic [dbits-1:0] i_wdata;
  logic             i_flush_all;
  logic             o_busy;
  logic             o_rvalid;
  logic [dbits-1:0] o_rdata;

  modport slave (
    input  i_req_valid, i_addr, i_wena, i_wmask, i_wdata, i_flush_all,
    output o_req_ready, o_busy, o_rvalid, o_rdata
  );

  modport master (
    output i_req_valid, i_addr, i_wena, i_wmask, i_wdata, i_flush_all,
    input  o_req_ready, o_busy, o_rvalid, o_rdata
  );

endinterface

// File: rtl/ram_mmu_flush_tech_bitwe_core.sv
// Raw single-port storage: per-bit write enable, read-first synchronous read, no reset.
module ram_mmu_bitwe_core #(
  parameter int abits = 6,
  parameter int dbits = 104
) (
  input  logic             i_clk,
  input  logic [abits-1:0] i_addr,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [dbits-1:0] i_wmask,
  input  logic [dbits-1:0] i_wdata,
  output logic [dbits-1:0] o_rdata
);

  logic [dbits-1:0] r_mem [(1 << abits)];

  // Read data only moves on a read strobe, so it holds across flush writes.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= (r_mem[i_addr] & ~i_wmask) | (i_wdata & i_wmask);
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/ram_mmu_flush_tech.sv
// MMU/TLB storage RAM with flush sequencer, selectable read latency and read-during-write mode.
module ram_mmu_flush_tech
  import ram_mmu_pkg::*;
#(
  parameter int               abits      = 6,
  parameter int               dbits      = 104,
  parameter int               RD_LATENCY = 1,
  parameter int               WR_MODE    = 0,
  parameter logic [dbits-1:0] INIT_VALUE = '0
) (
  input logic                  i_clk,
  input logic                  i_rst,
  ram_mmu_flush_tech_if.slave  io_bus
);

  localparam int               DEPTH    = 1 << abits;
  localparam logic [abits-1:0] LAST_IDX = abits'(DEPTH - 1);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_mmu_flush_tech: RD_LATENCY must be 1 or 2");
  end
  if (WR_MODE != WR_NO_CHANGE && WR_MODE != WR_WRITE_FIRST) begin : g_bad_wrmode
    $error("ram_mmu_flush_tech: WR_MODE must be 0 or 1");
  end

  flush_state_e     r_state;
  logic [abits-1:0] r_cnt;
  logic             r_busy;

  logic             w_flushing;
  logic             w_accept;
  logic             w_rd_pulse;
  logic             w_core_we;
  logic [abits-1:0] w_core_addr;
  logic [dbits-1:0] w_core_wmask;
  logic [dbits-1:0] w_core_wdata;
  logic [dbits-1:0] w_core_rdata;
  logic [dbits-1:0] w_rdata1;

  logic             r_v1;
  logic             r_w1;
  logic [dbits-1:0] r_m1;
  logic [dbits-1:0] r_d1;

  assign w_flushing         = (r_state == FLUSH);
  assign io_bus.o_req_ready = (r_state == IDLE) && !io_bus.i_flush_all;
  assign io_bus.o_busy      = r_busy;
  assign w_accept           = io_bus.i_req_valid && io_bus.o_req_ready;
  assign w_rd_pulse         = w_accept && (!io_bus.i_wena || (WR_MODE == WR_WRITE_FIRST));

  assign w_core_we    = w_flushing || (w_accept && io_bus.i_wena);
  assign w_core_addr  = w_flushing ? r_cnt      : io_bus.i_addr;
  assign w_core_wmask = w_flushing ? '1         : io_bus.i_wmask;
  assign w_core_wdata = w_flushing ? INIT_VALUE : io_bus.i_wdata;

  ram_mmu_bitwe_core #(
    .abits (abits),
    .dbits (dbits)
  ) u_core (
    .i_clk   (i_clk),
    .i_addr  (w_core_addr),
    .i_we    (w_core_we),
    .i_re    (w_rd_pulse),
    .i_wmask (w_core_wmask),
    .i_wdata (w_core_wdata),
    .o_rdata (w_core_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= FLUSH;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (io_bus.i_flush_all) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        FLUSH: begin
          if (io_bus.i_flush_all) begin
            r_cnt <= '0;
          end else if (r_cnt == LAST_IDX) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Write-first result is rebuilt from the read-first core word plus the captured mask/data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_w1 <= 1'b0;
      r_m1 <= '0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd_pulse;
      if (w_rd_pulse) begin
        r_w1 <= io_bus.i_wena;
        r_m1 <= io_bus.i_wmask;
        r_d1 <= io_bus.i_wdata;
      end
    end
  end

  assign w_rdata1 = r_w1 ? ((w_core_rdata & ~r_m1) | (r_d1 & r_m1)) : w_core_rdata;

  if (RD_LATENCY == 2) begin : g_lat2
    logic             r_v2;
    logic [dbits-1:0] r_d2;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_d2 <= w_rdata1;
        end
      end
    end

    assign io_bus.o_rvalid = r_v2;
    assign io_bus.o_rdata  = r_d2;
  end else begin : g_lat1
    // Core storage has no reset, so the output is forced to zero until the first result.
    logic r_seen;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_seen <= 1'b0;
      end else if (w_rd_pulse) begin
        r_seen <= 1'b1;
      end
    end

    assign io_bus.o_rvalid = r_v1;
    assign io_bus.o_rdata  = r_seen ? w_rdata1 : '0;
  end

endmodule
